pwm_deadtime_gen: RTL
=====================

// Module: pwm_deadtime_gen
// PURPOSE
//   Three-phase complementary gate-signal generator with dead-time insertion and fault latch.
//   Sits directly downstream of the three-phase PWM counter/compare stage. It consumes that
//   stage's PWM[2:0] and drives high-side/low-side gate pairs per phase.
//   Guarantees GateHi[i] and GateLo[i] are never both high. Forces all gates low on fault.
// PARAMETERS
//   CNT_W   16   width of DeadTime and the per-phase dead-time counters
// PORTS
//   Clk           in   1       system clock
//   Reset_n       in   1       reset, synchronous, active-low
//   Enable        in   1       1 = run phase FSMs; 0 = all phases IDLE, gates low
//   DeadTime      in   CNT_W   dead-time length in Clk cycles (0 treated as 1)
//   PwmIn         in   3       per-phase command from upstream PWM stage (1 = high side)
//   Fault         in   1       synchronous fault request, active-high
//   FaultClear    in   1       one-cycle clear request for the fault latch
//   GateHi        out  3       high-side gate drive, registered
//   GateLo        out  3       low-side gate drive, registered
//   FaultLatched  out  1       fault latch status, registered
// BEHAVIOUR
//   Reset (Reset_n=0 at edge): all FSMs IDLE, counters 0, GateHi=GateLo=0, FaultLatched=0.
//   Outputs are registered in the same always block as the state; they change on the same
//     edge as the state transition. No combinational path from inputs to outputs.
//   Per-phase FSM i (3 identical instances), states and outputs (Hi/Lo):
//     IDLE 0/0, LO_ON 0/1, DT_TO_HI 0/0, HI_ON 1/0, DT_TO_LO 0/0.
//   Let Dm = max(DeadTime,1). On entry to a DT_* state, cnt <= Dm-1.
//   Inside DT_*: if cnt!=0, decrement; if cnt==0, move to the target ON state.
//   The both-off interval is therefore exactly Dm cycles.
//   DeadTime is sampled only on DT_* entry; a change mid-interval affects the next interval only.
//   Transitions, evaluated each edge while Enable=1 and FaultLatched=0:
//     IDLE:     PwmIn[i]=1 -> DT_TO_HI; else -> DT_TO_LO   (dead time always precedes first ON)
//     LO_ON:    PwmIn[i]=1 -> DT_TO_HI
//     HI_ON:    PwmIn[i]=0 -> DT_TO_LO
//     DT_TO_HI: PwmIn[i]=0 -> LO_ON immediately (pulse shorter than Dm is swallowed);
//               else cnt==0 -> HI_ON
//     DT_TO_LO: PwmIn[i]=1 -> HI_ON immediately; else cnt==0 -> LO_ON
//   Timing: PwmIn[i] rises, sampled at edge k, in LO_ON: GateLo[i]=0 at edge k; GateHi[i]=1 at edge k+Dm.
//     Falling edge of PwmIn[i] is symmetric.
//   Enable=0 at an edge: all FSMs -> IDLE, all gates 0 at that edge. Counters are don't-care.
//   Fault: Fault=1 sampled at edge -> FaultLatched=1, all FSMs IDLE, gates 0 at that edge.
//     Gates stay 0 while FaultLatched=1, regardless of Enable and PwmIn.
//   FaultClear=1 with Fault=0 -> FaultLatched=0 at that edge; FSMs leave IDLE from the next edge.
//   Fault=1 and FaultClear=1 in the same cycle: fault wins, latch stays/sets 1.
//   Priority per edge: Reset_n > Fault/FaultLatched > Enable > FSM transition.
//   Phases are fully independent. Simultaneous edges on several PwmIn bits are handled in parallel.
//   Invariant, all cycles: (GateHi & GateLo) == 3'b000.
// TESTING
//   1. DeadTime=4, phase 0 in LO_ON, PwmIn[0] 0->1 at edge k
//      -> GateLo[0]=0 at k, GateHi[0]=1 at k+4, both low for exactly 4 cycles.
//   2. DeadTime=0, toggle PwmIn[1] -> exactly 1 both-off cycle on every transition, never overlap.
//   3. DeadTime=8, 3-cycle high pulse on PwmIn[2] from LO_ON
//      -> GateHi[2] never rises; GateLo[2] low 3 cycles then back to 1.
//   4. Running 3-phase PWM, Fault=1 for 1 cycle -> all gates 0 same edge, FaultLatched=1.
//      FaultClear with Fault=1 is ignored; FaultClear with Fault=0 clears it;
//      gates resume after Dm cycles of dead time.
//   5. Change DeadTime 4->10 while a phase is in DT_TO_HI
//      -> current interval stays 4, next interval is 10.
//   6. Reset_n=0 mid dead-time, and Enable=0 mid HI_ON -> all outputs 0 that edge.
//      Random PwmIn/Enable/Fault soak with assertion (GateHi & GateLo)==0.

Source files
------------

// File: rtl/pwm_deadtime_gen.sv
// rtl/pwm_deadtime_gen.sv - three-phase complementary gate driver with dead time and fault latch
//
// Purpose:
//   Turns the three PWM commands coming from the counter/compare stage into
//   high-side / low-side gate pairs. Whenever a phase changes side, both
//   gates of that phase are held off for max(DeadTime,1) cycles before the
//   new side is driven. A fault forces every gate low and is latched until
//   explicitly cleared.
//
// Ports:
//   Clk           in   1       system clock
//   Reset_n       in   1       synchronous active-low reset
//   Enable        in   1       1 = phases run, 0 = all phases idle with gates low
//   DeadTime      in   CNT_W   both-off interval length in Clk cycles (0 acts as 1)
//   PwmIn         in   3       per-phase command, 1 = high side
//   Fault         in   1       synchronous fault request, active-high
//   FaultClear    in   1       one-cycle request to clear the fault latch
//   GateHi        out  3       registered high-side gate drive
//   GateLo        out  3       registered low-side gate drive
//   FaultLatched  out  1       registered fault latch status

module pwm_deadtime_gen #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Enable,
    input  logic [CNT_W-1:0] DeadTime,
    input  logic [2:0]       PwmIn,
    input  logic             Fault,
    input  logic             FaultClear,
    output logic [2:0]       GateHi,
    output logic [2:0]       GateLo,
    output logic             FaultLatched
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LO_ON    = 3'd1;
    localparam logic [2:0] ST_DT_TO_HI = 3'd2;
    localparam logic [2:0] ST_HI_ON    = 3'd3;
    localparam logic [2:0] ST_DT_TO_LO = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q [3];
    logic [2:0]       state_d [3];
    logic [CNT_W-1:0] cnt_q   [3];
    logic [CNT_W-1:0] cnt_d   [3];

    logic [2:0] gate_hi_q;
    logic [2:0] gate_hi_d;
    logic [2:0] gate_lo_q;
    logic [2:0] gate_lo_d;
    logic       fault_latched_q;
    logic       fault_latched_d;

    logic             inhibit;
    logic [CNT_W-1:0] dt_load;

    // Value loaded into a counter on dead-time entry: Dm-1 with Dm = max(DeadTime,1).
    // The counter then runs Dm-1 .. 0, so the both-off interval is exactly Dm cycles.
    assign dt_load = (DeadTime == CNT_ZERO) ? CNT_ZERO : (DeadTime - CNT_ONE);

    // A fresh fault request or a still-latched fault holds every phase idle.
    // On the clearing edge the latch was still set, so phases only restart
    // from the following edge.
    assign inhibit = Fault | fault_latched_q;

    always_comb begin
        // Fault wins over a simultaneous clear request.
        fault_latched_d = Fault | (fault_latched_q & ~FaultClear);
        gate_hi_d       = 3'b000;
        gate_lo_d       = 3'b000;

        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];

            if (inhibit || !Enable) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = CNT_ZERO;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        // Dead time always precedes the first ON state after idle.
                        state_d[i] = PwmIn[i] ? ST_DT_TO_HI : ST_DT_TO_LO;
                        cnt_d[i]   = dt_load;
                    end
                    ST_LO_ON: begin
                        if (PwmIn[i]) begin
                            state_d[i] = ST_DT_TO_HI;
                            cnt_d[i]   = dt_load;
                        end
                    end
                    ST_HI_ON: begin
                        if (!PwmIn[i]) begin
                            state_d[i] = ST_DT_TO_LO;
                            cnt_d[i]   = dt_load;
                        end
                    end
                    ST_DT_TO_HI: begin
                        // A command that drops back during the interval is swallowed:
                        // return straight to the low side.
                        if (!PwmIn[i]) begin
                            state_d[i] = ST_LO_ON;
                        end else if (cnt_q[i] == CNT_ZERO) begin
                            state_d[i] = ST_HI_ON;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                    ST_DT_TO_LO: begin
                        if (PwmIn[i]) begin
                            state_d[i] = ST_HI_ON;
                        end else if (cnt_q[i] == CNT_ZERO) begin
                            state_d[i] = ST_LO_ON;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = CNT_ZERO;
                    end
                endcase
            end

            // Gates are decoded from the next state so they register on the
            // same edge as the state change; HI and LO are distinct states,
            // so the pair can never be high together.
            gate_hi_d[i] = (state_d[i] == ST_HI_ON);
            gate_lo_d[i] = (state_d[i] == ST_LO_ON);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= CNT_ZERO;
            end
            gate_hi_q       <= 3'b000;
            gate_lo_q       <= 3'b000;
            fault_latched_q <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            gate_hi_q       <= gate_hi_d;
            gate_lo_q       <= gate_lo_d;
            fault_latched_q <= fault_latched_d;
        end
    end

    assign GateHi       = gate_hi_q;
    assign GateLo       = gate_lo_q;
    assign FaultLatched = fault_latched_q;

endmodule
